pix_filter3x3: RTL
==================

# pix_filter3x3

Streaming 3×3 spatial filter between the camera pixel-capture stage and the frame RAM write port. Consumes the capture stage's write stream (`write_en`, 12-bit RGB444 pixel, 19-bit raster address for 640×480) and emits a filtered write stream of the same format. The block supports four per-frame modes: bypass, grayscale, 3×3 mean, and 3×3 sharpen. It runs in the pixel-clock domain and holds two lines of history in on-chip RAM.

## Interface
Parameters:
- `H_RES`, 640, pixels per line
- `V_RES`, 480, lines per frame

Ports:
- `pclk`  in  1  pixel clock, the only clock
- `rst`  in  1  asynchronous, active-high reset
- `mode`  in  2  filter select: 0 bypass, 1 gray, 2 mean, 3 sharpen
- `in_en`  in  1  input pixel valid, one cycle per pixel
- `in_rgb`  in  12  input pixel {R[11:8], G[7:4], B[3:0]}
- `in_addr`  in  19  input raster address, y*H_RES+x
- `out_en`  out  1  output write strobe
- `out_rgb`  out  12  output pixel
- `out_addr`  out  19  output RAM address

## Operation
- Frame sync: `in_en` with `in_addr==0` starts a frame.
  - `mode` is latched into `mode_q` at frame start, so a mode change never tears a frame.
  - Column counter `col` is cleared to 0 at frame start and increments on each `in_en`, wrapping at H_RES-1.
  - Row counter `row` increments when `col` wraps.
- Unsynced: after reset, `synced=0` and all inputs are discarded (no `out_en`) until the first frame start.
- Line buffers: two H_RES×12 memories, addressed by `col`.
  - On each `in_en`, read `lb1[col]` (row y-1) and `lb0[col]` (row y-2) in the same cycle.
  - Write `in_rgb` into `lb1[col]` and the old `lb1[col]` into `lb0[col]` (read-before-write).
- Window: three 3-column shift registers (rows y-2, y-1, y), shifted on each `in_en`.
  - The centre is pixel (x-1, y-1) relative to the input at (x, y).
- Mode 0 (bypass): `out_rgb=in_rgb`, `out_addr=in_addr`, one output per input, every address.
- Mode 1 (gray): `Y=(2R+5G+B)>>3`, range 0..15; `out_rgb={Y,Y,Y}`, `out_addr=in_addr`.
- Modes 2/3 (spatial): each input with `in_addr ≥ H_RES+1` produces one output with `out_addr=in_addr-(H_RES+1)`.
  - Inputs with `in_addr < H_RES+1` produce no output.
  - Centres at addresses ≥ H_RES*V_RES-(H_RES+1) (row 479 and pixel (639,478)) are never written; RAM keeps prior content.
- Border: if the centre column is 0 or H_RES-1, or the centre row is 0, the window wraps. In that case output the centre pixel unmodified.
- Mean (mode 2), per channel:
  - `s` = sum of 9 nibbles, 8 bits, max 135.
  - `out = floor(s/9)`. `(s*57)>>9` is permitted and is exact over 0..135.
- Sharpen (mode 3), per channel:
  - `v = 5*c − (up+down+left+right)`, signed 8-bit, range −60..75.
  - Clamp to 0..15.
- Frame start arriving mid-frame (short frame): counters resync immediately. Window contents are stale until row 2; the border rule does not mask this.
- Reset mid-operation: `out_en` drops, counters and `synced` clear, and the pipeline is flushed. Line-buffer contents are don't-care.

## Timing
- Fixed latency of 2 `pclk` from `in_en` to `out_en` in every mode.
  - Stage 1: line-buffer read, window shift, counter update.
  - Stage 2: arithmetic, registered outputs.
- `out_en` is a single-cycle pulse for each qualifying `in_en`. Back-to-back `in_en` is supported at full rate.
- Reset values: `out_en=0`, `out_rgb=0`, `out_addr=0`, `col=0`, `row=0`, `mode_q=0`, `synced=0`.
- `mode_q` takes effect for the frame-start pixel itself.

## Structure
- Shared package `filt_pkg`:
  - `H_RES`, `V_RES`
  - mode encodings `MODE_BYPASS`, `MODE_GRAY`, `MODE_MEAN`, `MODE_SHARP`
  - `PIX_W=12`, `ADDR_W=19`
- Sub-module `line_buf2`: dual H_RES×12 line memory with read-before-write, sized to infer block RAM with a 1-cycle read.
- Per-channel arithmetic is generated three times from one function (mean, sharpen clamp).

## Test plan
- Bypass, frame of `in_rgb=in_addr[11:0]` → every address emitted with identical data, `out_en` exactly 2 cycles after `in_en`.
- Gray, `in_rgb=12'hF00` → `out_rgb=12'h333`; `12'h0F0` → `12'h999`; `12'hFFF` → `12'hFFF`.
- Mean, constant frame `12'h7A3` → every emitted pixel `12'h7A3`. First `out_en` at input address 641 with `out_addr=0`. No output for addresses 0..640.
- Mean, single `12'hFFF` impulse at (320,240) on black → centres (319..321, 239..241) output `12'h111`; all others `0`.
- Sharpen, the same impulse → centre `12'hFFF`; the 4-neighbours clamp to `0`.
- `mode` toggled mid-frame → no change until the next `in_addr==0`. Reset asserted mid-frame → `out_en=0` until the next frame start, then output resumes correctly.

Source files
------------

// File: rtl/filt_pkg.sv
// Shared constants, mode encodings and per-channel arithmetic for the 3x3 pixel filter.
package filt_pkg;

    localparam int unsigned H_RES  = 640;
    localparam int unsigned V_RES  = 480;
    localparam int unsigned PIX_W  = 12;
    localparam int unsigned ADDR_W = 19;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_GRAY   = 2'd1,
        MODE_MEAN   = 2'd2,
        MODE_SHARP  = 2'd3
    } mode_e;

    // One column of the 3x3 window: rows y-2, y-1, y.
    typedef struct packed {
        logic [PIX_W-1:0] top;
        logic [PIX_W-1:0] mid;
        logic [PIX_W-1:0] bot;
    } wcol_t;

    // Y = (2R + 5G + B) >> 3
    function automatic logic [3:0] gray4(input logic [PIX_W-1:0] rgb);
        logic [6:0] acc;
        acc = 7'({rgb[11:8], 1'b0}) + 7'(rgb[7:4]) * 7'd5 + 7'(rgb[3:0]);
        return 4'(acc >> 3);
    endfunction

    // floor(sum/9) via (sum*57)>>9, exact for sums up to 135
    function automatic logic [3:0] mean9(input logic [35:0] nibs);
        logic [7:0] s;
        s = '0;
        for (int i = 0; i < 9; i++) begin
            s = s + 8'(nibs[4*i +: 4]);
        end
        return 4'((14'(s) * 14'd57) >> 9);
    endfunction

    // 5c - (u+d+l+r), clamped to 0..15
    function automatic logic [3:0] sharpen(input logic [3:0] c, input logic [3:0] u,
                                           input logic [3:0] d, input logic [3:0] l,
                                           input logic [3:0] r);
        logic [7:0] pos;
        logic [7:0] neg;
        pos = 8'(c) * 8'd5;
        neg = 8'(u) + 8'(d) + 8'(l) + 8'(r);
        if (pos <= neg) begin
            return 4'd0;
        end
        if ((pos - neg) > 8'd15) begin
            return 4'hF;
        end
        return 4'(pos - neg);
    endfunction

endpackage

// File: rtl/line_buf2.sv
// Two-line history memory: lb1 holds row y-1, lb0 holds row y-2, read-before-write with 1-cycle read.
module line_buf2 #(
    parameter int unsigned DEPTH = filt_pkg::H_RES,
    parameter int unsigned W     = filt_pkg::PIX_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rd0,
    output logic [W-1:0]             rd1
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem0 [DEPTH];
    logic [W-1:0]  mem1 [DEPTH];
    logic [W-1:0]  rd0_q;
    logic [W-1:0]  rd1_q;
    logic          wr_pend_q, wr_pend_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;

    // lb0 is fed from lb1's registered read data one cycle later, keeping both arrays single-port BRAM.
    always_comb begin
        wr_pend_d = en;
        wr_addr_d = wr_addr_q;
        if (en) begin
            wr_addr_d = addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_pend_q <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            wr_pend_q <= wr_pend_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            rd1_q      <= mem1[addr];
            rd0_q      <= mem0[addr];
            mem1[addr] <= wdata;
        end
        if (wr_pend_q) begin
            mem0[wr_addr_q] <= rd1_q;
        end
    end

    assign rd0 = rd0_q;
    assign rd1 = rd1_q;

endmodule

// File: rtl/pix_filter3x3.sv
// Streaming 3x3 filter (bypass / gray / mean / sharpen) on the capture-to-frame-RAM write stream.
module pix_filter3x3 #(
    parameter int unsigned H_RES = filt_pkg::H_RES,
    parameter int unsigned V_RES = filt_pkg::V_RES
) (
    input  logic                        pclk,
    input  logic                        rst,
    input  logic [1:0]                  mode,
    input  logic                        in_en,
    input  logic [filt_pkg::PIX_W-1:0]  in_rgb,
    input  logic [filt_pkg::ADDR_W-1:0] in_addr,
    output logic                        out_en,
    output logic [filt_pkg::PIX_W-1:0]  out_rgb,
    output logic [filt_pkg::ADDR_W-1:0] out_addr
);

    import filt_pkg::*;

    localparam int unsigned COL_W     = $clog2(H_RES);
    localparam int unsigned ROW_W     = $clog2(V_RES);
    localparam int unsigned FRAME_PIX = H_RES * V_RES;

    logic              synced_q, synced_d;
    mode_e             mode_q, mode_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;

    logic              s1_v_q, s1_v_d;
    mode_e             s1_mode_q, s1_mode_d;
    logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
    logic              s1_border_q, s1_border_d;
    logic [PIX_W-1:0]  s1_rgb_q, s1_rgb_d;
    wcol_t             wa_q, wa_d;
    wcol_t             wb_q, wb_d;

    logic              out_en_q, out_en_d;
    logic [PIX_W-1:0]  out_rgb_q, out_rgb_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;

    logic              fs_c, adv_c;
    mode_e             mode_cur_c;
    logic [COL_W-1:0]  col_cur_c;
    logic [ROW_W-1:0]  row_cur_c;
    logic [PIX_W-1:0]  lb_rd0, lb_rd1;
    logic [PIX_W-1:0]  mean_c, sharp_c;
    logic [3:0]        gray_c;

    assign fs_c       = in_en && (in_addr == '0);
    assign adv_c      = in_en && (synced_q || fs_c);
    assign mode_cur_c = fs_c ? mode_e'(mode) : mode_q;
    assign col_cur_c  = fs_c ? '0 : col_q;
    assign row_cur_c  = fs_c ? '0 : row_q;

    line_buf2 #(.DEPTH(H_RES), .W(PIX_W)) u_lb (
        .clk   (pclk),
        .rst   (rst),
        .en    (in_en),
        .addr  (col_cur_c),
        .wdata (in_rgb),
        .rd0   (lb_rd0),
        .rd1   (lb_rd1)
    );

    // Stage 1: frame sync, counters, window shift, output qualification.
    // After this stage the window columns are wa (x-2), wb (x-1) and {lb_rd0, lb_rd1, s1_rgb} (x).
    always_comb begin
        synced_d    = synced_q;
        mode_d      = mode_q;
        col_d       = col_q;
        row_d       = row_q;
        s1_v_d      = 1'b0;
        s1_mode_d   = s1_mode_q;
        s1_addr_d   = s1_addr_q;
        s1_border_d = s1_border_q;
        s1_rgb_d    = s1_rgb_q;
        wa_d        = wa_q;
        wb_d        = wb_q;

        if (in_en) begin
            s1_rgb_d = in_rgb;
            wa_d     = wb_q;
            wb_d     = '{top: lb_rd0, mid: lb_rd1, bot: s1_rgb_q};
        end
        if (fs_c) begin
            synced_d = 1'b1;
            mode_d   = mode_e'(mode);
        end
        if (adv_c) begin
            if (col_cur_c == COL_W'(H_RES - 1)) begin
                col_d = '0;
                row_d = row_cur_c + ROW_W'(1);
            end else begin
                col_d = col_cur_c + COL_W'(1);
                row_d = row_cur_c;
            end
            s1_mode_d   = mode_cur_c;
            // Centre at column 0, column H_RES-1 or row 0 has a wrapped window.
            s1_border_d = (col_cur_c <= COL_W'(1)) || (row_cur_c == ROW_W'(1));
            if (mode_cur_c == MODE_BYPASS || mode_cur_c == MODE_GRAY) begin
                s1_v_d    = 1'b1;
                s1_addr_d = in_addr;
            end else if (in_addr >= ADDR_W'(H_RES + 1) && in_addr < ADDR_W'(FRAME_PIX)) begin
                s1_v_d    = 1'b1;
                s1_addr_d = in_addr - ADDR_W'(H_RES + 1);
            end
        end
    end

    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        localparam int unsigned LSB = 4 * ch;
        assign mean_c[LSB +: 4] = mean9({wa_q.top[LSB +: 4], wa_q.mid[LSB +: 4], wa_q.bot[LSB +: 4],
                                         wb_q.top[LSB +: 4], wb_q.mid[LSB +: 4], wb_q.bot[LSB +: 4],
                                         lb_rd0[LSB +: 4],   lb_rd1[LSB +: 4],   s1_rgb_q[LSB +: 4]});
        assign sharp_c[LSB +: 4] = sharpen(wb_q.mid[LSB +: 4], wb_q.top[LSB +: 4], wb_q.bot[LSB +: 4],
                                           wa_q.mid[LSB +: 4], lb_rd1[LSB +: 4]);
    end

    assign gray_c = gray4(s1_rgb_q);

    // Stage 2: mode arithmetic and registered write stream.
    always_comb begin
        out_en_d   = s1_v_q;
        out_rgb_d  = out_rgb_q;
        out_addr_d = out_addr_q;
        if (s1_v_q) begin
            out_addr_d = s1_addr_q;
            unique case (s1_mode_q)
                MODE_BYPASS: out_rgb_d = s1_rgb_q;
                MODE_GRAY:   out_rgb_d = {gray_c, gray_c, gray_c};
                MODE_MEAN:   out_rgb_d = s1_border_q ? wb_q.mid : mean_c;
                MODE_SHARP:  out_rgb_d = s1_border_q ? wb_q.mid : sharp_c;
            endcase
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            synced_q    <= 1'b0;
            mode_q      <= MODE_BYPASS;
            col_q       <= '0;
            row_q       <= '0;
            s1_v_q      <= 1'b0;
            s1_mode_q   <= MODE_BYPASS;
            s1_addr_q   <= '0;
            s1_border_q <= 1'b0;
            s1_rgb_q    <= '0;
            wa_q        <= '0;
            wb_q        <= '0;
            out_en_q    <= 1'b0;
            out_rgb_q   <= '0;
            out_addr_q  <= '0;
        end else begin
            synced_q    <= synced_d;
            mode_q      <= mode_d;
            col_q       <= col_d;
            row_q       <= row_d;
            s1_v_q      <= s1_v_d;
            s1_mode_q   <= s1_mode_d;
            s1_addr_q   <= s1_addr_d;
            s1_border_q <= s1_border_d;
            s1_rgb_q    <= s1_rgb_d;
            wa_q        <= wa_d;
            wb_q        <= wb_d;
            out_en_q    <= out_en_d;
            out_rgb_q   <= out_rgb_d;
            out_addr_q  <= out_addr_d;
        end
    end

    assign out_en   = out_en_q;
    assign out_rgb  = out_rgb_q;
    assign out_addr = out_addr_q;

endmodule
